// File: rtl/mux_nto1_pipe.sv
// Registered N-to-1 selector with valid/ready handshake, 1-entry skid buffer and select tagging.
// Latency: 1 cycle from accept to valid_o when the output stage is empty or draining.
// Backpressure: ready_o drops only when the skid stage is full; ready_o never depends on ready_i.
//
// Ports:
//   clk_i     - clock, rising edge
//   rst_i     - synchronous reset, active low
//   data_i    - N_IN packed inputs, input k = data_i[k*SIZE +: SIZE]
//   select_i  - input index, sampled with valid_i
//   valid_i   - upstream item present
//   ready_o   - block can accept an item this cycle
//   flush_i   - discard all held items (wins over a same-cycle accept)
//   data_o    - selected data, registered
//   sel_o     - select value that produced data_o
//   sel_err_o - data_o came from an out-of-range select (DEFAULT_VAL emitted)
//   valid_o   - data_o/sel_o/sel_err_o hold a valid item
//   ready_i   - downstream accepts the item this cycle
module mux_nto1_pipe #(
    parameter int                SIZE        = 32,
    parameter int                N_IN        = 4,
    parameter int                SEL_W       = 2,
    parameter logic [SIZE-1:0]   DEFAULT_VAL = '0
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [N_IN*SIZE-1:0] data_i,
    input  logic [SEL_W-1:0]     select_i,
    input  logic                 valid_i,
    output logic                 ready_o,
    input  logic                 flush_i,
    output logic [SIZE-1:0]      data_o,
    output logic [SEL_W-1:0]     sel_o,
    output logic                 sel_err_o,
    output logic                 valid_o,
    input  logic                 ready_i
);

    // Output stage
    logic [SIZE-1:0]  out_dat_q, out_dat_d;
    logic [SEL_W-1:0] out_sel_q, out_sel_d;
    logic             out_err_q, out_err_d;
    logic             out_vld_q, out_vld_d;

    // Skid stage
    logic [SIZE-1:0]  skid_dat_q, skid_dat_d;
    logic [SEL_W-1:0] skid_sel_q, skid_sel_d;
    logic             skid_err_q, skid_err_d;
    logic             skid_vld_q, skid_vld_d;

    // Selected input for the item currently offered
    logic [SIZE-1:0]  in_dat;
    logic             in_err;
    logic [31:0]      sel_ext;

    logic             accept;
    logic             out_free;

    // Out-of-range compare done at 32 bits so N_IN == 2**SEL_W does not overflow.
    always_comb begin
        sel_ext = 32'(select_i);
        in_err  = (sel_ext >= 32'(N_IN));
        in_dat  = DEFAULT_VAL;
        for (int k = 0; k < N_IN; k++) begin
            if (sel_ext == 32'(k)) begin
                in_dat = data_i[k*SIZE +: SIZE];
            end
        end
    end

    assign ready_o  = rst_i && !skid_vld_q;
    assign accept   = valid_i && ready_o;
    // OUT can take a new item when it is empty or being delivered this cycle.
    assign out_free = !out_vld_q || ready_i;

    always_comb begin
        out_dat_d  = out_dat_q;
        out_sel_d  = out_sel_q;
        out_err_d  = out_err_q;
        out_vld_d  = out_vld_q;
        skid_dat_d = skid_dat_q;
        skid_sel_d = skid_sel_q;
        skid_err_d = skid_err_q;
        skid_vld_d = skid_vld_q;

        if (flush_i) begin
            out_vld_d  = 1'b0;
            skid_vld_d = 1'b0;
        end else if (out_free) begin
            if (skid_vld_q) begin
                // ready_o was low, so no accept can coincide with the skid drain.
                out_dat_d  = skid_dat_q;
                out_sel_d  = skid_sel_q;
                out_err_d  = skid_err_q;
                out_vld_d  = 1'b1;
                skid_vld_d = 1'b0;
            end else if (accept) begin
                out_dat_d = in_dat;
                out_sel_d = select_i;
                out_err_d = in_err;
                out_vld_d = 1'b1;
            end else begin
                out_vld_d = 1'b0;
            end
        end else if (accept) begin
            // OUT is stalled: park the new item, keep outputs stable.
            skid_dat_d = in_dat;
            skid_sel_d = select_i;
            skid_err_d = in_err;
            skid_vld_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            out_dat_q  <= '0;
            out_sel_q  <= '0;
            out_err_q  <= 1'b0;
            out_vld_q  <= 1'b0;
            skid_dat_q <= '0;
            skid_sel_q <= '0;
            skid_err_q <= 1'b0;
            skid_vld_q <= 1'b0;
        end else begin
            out_dat_q  <= out_dat_d;
            out_sel_q  <= out_sel_d;
            out_err_q  <= out_err_d;
            out_vld_q  <= out_vld_d;
            skid_dat_q <= skid_dat_d;
            skid_sel_q <= skid_sel_d;
            skid_err_q <= skid_err_d;
            skid_vld_q <= skid_vld_d;
        end
    end

    assign data_o    = out_dat_q;
    assign sel_o     = out_sel_q;
    assign sel_err_o = out_err_q;
    assign valid_o   = out_vld_q;

endmodule

// File: tb/tb_mux_nto1_pipe.sv
// Directed bench for mux_nto1_pipe: a 4-input instance and a 3-input instance with a
// non-zero default value, both on one clock. Inputs change 1 time unit after the rising
// edge; outputs are checked at the same point, i.e. after the edge has updated the state.
module tb_mux_nto1_pipe;

    logic clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // 4-input instance
    logic [127:0] data4;
    logic [1:0]   sel4;
    logic         valid4, ready_o4, flush4, ready_i4;
    logic [31:0]  data_o4;
    logic [1:0]   sel_o4;
    logic         err_o4, valid_o4;
    logic         rst4;

    // 3-input instance
    logic [95:0]  data3;
    logic [1:0]   sel3;
    logic         valid3, ready_o3, flush3, ready_i3;
    logic [31:0]  data_o3;
    logic [1:0]   sel_o3;
    logic         err_o3, valid_o3;
    logic         rst3;

    int n_cmp = 0;
    int n_err = 0;

    mux_nto1_pipe #(.SIZE(32), .N_IN(4), .SEL_W(2), .DEFAULT_VAL(32'h0)) u_dut4 (
        .clk_i(clk_i), .rst_i(rst4), .data_i(data4), .select_i(sel4), .valid_i(valid4),
        .ready_o(ready_o4), .flush_i(flush4), .data_o(data_o4), .sel_o(sel_o4),
        .sel_err_o(err_o4), .valid_o(valid_o4), .ready_i(ready_i4)
    );

    mux_nto1_pipe #(.SIZE(32), .N_IN(3), .SEL_W(2), .DEFAULT_VAL(32'hDEAD)) u_dut3 (
        .clk_i(clk_i), .rst_i(rst3), .data_i(data3), .select_i(sel3), .valid_i(valid3),
        .ready_o(ready_o3), .flush_i(flush3), .data_o(data_o3), .sel_o(sel_o3),
        .sel_err_o(err_o3), .valid_o(valid_o3), .ready_i(ready_i3)
    );

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [31:0] exp_stream [4];
        exp_stream[0] = 32'h11;
        exp_stream[1] = 32'h22;
        exp_stream[2] = 32'h33;
        exp_stream[3] = 32'h44;

        data4  = {32'h44, 32'h33, 32'h22, 32'h11};
        data3  = {32'h33, 32'h22, 32'h11};
        sel4 = 2'd0; valid4 = 1'b0; flush4 = 1'b0; ready_i4 = 1'b1; rst4 = 1'b0;
        sel3 = 2'd0; valid3 = 1'b0; flush3 = 1'b0; ready_i3 = 1'b1; rst3 = 1'b0;

        // Reset held two cycles
        tick();
        tick();
        chk("rst_valid_o", 64'(valid_o4), 64'd0);
        chk("rst_data_o", 64'(data_o4), 64'd0);
        chk("rst_sel_err_o", 64'(err_o4), 64'd0);
        chk("rst_ready_o_low", 64'(ready_o4), 64'd0);
        chk("rst3_data_o", 64'(data_o3), 64'd0);
        rst4 = 1'b1;
        rst3 = 1'b1;
        #1;
        chk("rst_ready_o_high", 64'(ready_o4), 64'd1);
        chk("rst3_ready_o_high", 64'(ready_o3), 64'd1);

        // Back-to-back stream, one item per cycle
        valid4 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            sel4 = 2'(i);
            tick();
            chk("stream_valid_o", 64'(valid_o4), 64'd1);
            chk("stream_data_o", 64'(data_o4), 64'(exp_stream[i]));
            chk("stream_sel_o", 64'(sel_o4), 64'(i));
            chk("stream_ready_o", 64'(ready_o4), 64'd1);
        end
        valid4 = 1'b0;
        tick();
        chk("stream_drain_valid_o", 64'(valid_o4), 64'd0);

        // Stall: A (sel 1) into OUT, B (sel 2) into SKID
        ready_i4 = 1'b0;
        valid4 = 1'b1;
        sel4 = 2'd1;
        tick();
        chk("stall_A_data_o", 64'(data_o4), 64'h22);
        chk("stall_A_ready_o", 64'(ready_o4), 64'd1);
        sel4 = 2'd2;
        tick();
        chk("stall_B_hold_data_o", 64'(data_o4), 64'h22);
        chk("stall_B_ready_o", 64'(ready_o4), 64'd0);
        // Item offered while ready_o=0 must not be taken
        sel4 = 2'd3;
        tick();
        chk("stall_hold_data_o", 64'(data_o4), 64'h22);
        chk("stall_hold_sel_o", 64'(sel_o4), 64'd1);
        chk("stall_hold_valid_o", 64'(valid_o4), 64'd1);
        valid4 = 1'b0;
        ready_i4 = 1'b1;
        tick();
        chk("stall_B_out_data_o", 64'(data_o4), 64'h33);
        chk("stall_B_out_sel_o", 64'(sel_o4), 64'd2);
        chk("stall_B_out_valid_o", 64'(valid_o4), 64'd1);
        chk("stall_ready_back", 64'(ready_o4), 64'd1);
        tick();
        chk("stall_done_valid_o", 64'(valid_o4), 64'd0);

        // Out-of-range select on the 3-input instance
        valid3 = 1'b1;
        sel3 = 2'd3;
        tick();
        chk("range_data_o", 64'(data_o3), 64'hDEAD);
        chk("range_sel_o", 64'(sel_o3), 64'd3);
        chk("range_sel_err_o", 64'(err_o3), 64'd1);
        sel3 = 2'd2;
        tick();
        chk("range_last_data_o", 64'(data_o3), 64'h33);
        chk("range_last_sel_err_o", 64'(err_o3), 64'd0);
        valid3 = 1'b0;
        tick();
        chk("range_drain_valid_o", 64'(valid_o3), 64'd0);

        // Flush with OUT and SKID full and an item offered
        ready_i4 = 1'b0;
        valid4 = 1'b1;
        sel4 = 2'd0;
        tick();
        sel4 = 2'd1;
        tick();
        chk("flush_pre_ready_o", 64'(ready_o4), 64'd0);
        flush4 = 1'b1;
        sel4 = 2'd3;
        tick();
        flush4 = 1'b0;
        valid4 = 1'b0;
        chk("flush_valid_o", 64'(valid_o4), 64'd0);
        chk("flush_ready_o", 64'(ready_o4), 64'd1);
        ready_i4 = 1'b1;
        tick();
        chk("flush_after_valid_o", 64'(valid_o4), 64'd0);
        // Flush beats an accept while ready_o=1
        flush4 = 1'b1;
        valid4 = 1'b1;
        sel4 = 2'd3;
        tick();
        flush4 = 1'b0;
        valid4 = 1'b0;
        chk("flush_vs_accept_valid_o", 64'(valid_o4), 64'd0);
        tick();
        chk("flush_vs_accept_later", 64'(valid_o4), 64'd0);

        // Reset while OUT and SKID are full
        ready_i4 = 1'b0;
        valid4 = 1'b1;
        sel4 = 2'd2;
        tick();
        sel4 = 2'd3;
        tick();
        chk("midrst_pre_valid_o", 64'(valid_o4), 64'd1);
        chk("midrst_pre_ready_o", 64'(ready_o4), 64'd0);
        valid4 = 1'b0;
        rst4 = 1'b0;
        tick();
        chk("midrst_valid_o", 64'(valid_o4), 64'd0);
        chk("midrst_data_o", 64'(data_o4), 64'd0);
        chk("midrst_ready_o", 64'(ready_o4), 64'd0);
        rst4 = 1'b1;
        ready_i4 = 1'b1;
        #1;
        chk("midrst_ready_back", 64'(ready_o4), 64'd1);
        tick();
        chk("midrst_items_lost", 64'(valid_o4), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
